// File: rtl/issue_hazard_unit_pkg.sv
// Shared register-file sizing and issue FSM state encoding for the dual-slot
// issue hazard logic.
package issue_hazard_unit_pkg;

    localparam int unsigned NUM_REGISTERS      = 32;
    localparam int unsigned NUM_REGISTERS_LOG2 = 5;

    typedef logic [NUM_REGISTERS_LOG2-1:0] reg_idx_t;

    typedef enum logic {
        ISSUE_RUN   = 1'b0,
        ISSUE_SPLIT = 1'b1
    } issue_state_t;

endpackage

// File: rtl/issue_hazard_unit_reg_scoreboard.sv
// Busy-bit scoreboard of registers awaiting an in-flight load result, with
// per-slot source lookups that bypass the load completing this cycle.
module reg_scoreboard
    import issue_hazard_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     set0,
    input  reg_idx_t set0_rd,
    input  logic     set1,
    input  reg_idx_t set1_rd,
    input  logic     clear,
    input  reg_idx_t clear_rd,
    input  reg_idx_t rs0,
    input  reg_idx_t rt0,
    input  reg_idx_t rs1,
    input  reg_idx_t rt1,
    output logic     blocked0,
    output logic     blocked1
);

    logic [NUM_REGISTERS-1:0] busy;
    logic [NUM_REGISTERS-1:0] busy_next;

    function automatic logic src_blocked(
        input logic [NUM_REGISTERS-1:0] busy_vec,
        input logic                     done,
        input reg_idx_t                 done_rd,
        input reg_idx_t                 src
    );
        return busy_vec[src] && !(done && (done_rd == src));
    endfunction

    // Clear is applied first so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (clear) busy_next[clear_rd] = 1'b0;
        if (set0)  busy_next[set0_rd]  = 1'b1;
        if (set1)  busy_next[set1_rd]  = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_next;
    end

    assign blocked0 = src_blocked(busy, clear, clear_rd, rs0) ||
                      src_blocked(busy, clear, clear_rd, rt0);
    assign blocked1 = src_blocked(busy, clear, clear_rd, rs1) ||
                      src_blocked(busy, clear, clear_rd, rt1);

endmodule

// File: rtl/issue_hazard_unit.sv
// Issue-side hazard unit: decides which slots of the IF/ID pair issue, stalls
// the front end, counts outstanding loads and registers the slot age bit.
module issue_hazard_unit
    import issue_hazard_unit_pkg::*;
#(
    parameter  int unsigned MAX_LOADS = 4,
    localparam int unsigned CNTW      = $clog2(MAX_LOADS + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            if_id_valid,
    input  reg_idx_t        if_id_rs0,
    input  reg_idx_t        if_id_rt0,
    input  reg_idx_t        if_id_rs1,
    input  reg_idx_t        if_id_rt1,
    input  reg_idx_t        if_id_rd0,
    input  reg_idx_t        if_id_rd1,
    input  logic            if_id_reg_write0,
    input  logic            if_id_reg_write1,
    input  logic            if_id_mem_read0,
    input  logic            if_id_mem_read1,
    input  logic            load_done,
    input  reg_idx_t        load_done_rd,
    output logic            stall,
    output logic            issue0,
    output logic            issue1,
    output logic            first,
    output logic [CNTW-1:0] loads_pending
);

    localparam int unsigned SUMW = CNTW + 2;

    issue_state_t    state;
    issue_state_t    next_state;
    logic            blocked0;
    logic            blocked1;
    logic            intra;
    logic            cap0;
    logic            cap01;
    logic            cap1;
    logic [SUMW-1:0] base;
    logic [SUMW-1:0] pending_next;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set0     (issue0 && if_id_mem_read0 && if_id_reg_write0 && (if_id_rd0 != '0)),
        .set0_rd  (if_id_rd0),
        .set1     (issue1 && if_id_mem_read1 && if_id_reg_write1 && (if_id_rd1 != '0)),
        .set1_rd  (if_id_rd1),
        .clear    (load_done),
        .clear_rd (load_done_rd),
        .rs0      (if_id_rs0),
        .rt0      (if_id_rt0),
        .rs1      (if_id_rs1),
        .rt1      (if_id_rt1),
        .blocked0 (blocked0),
        .blocked1 (blocked1)
    );

    assign intra = if_id_reg_write0 && (if_id_rd0 != '0) &&
                   ((if_id_rs1 == if_id_rd0) || (if_id_rt1 == if_id_rd0));

    // Capacity is judged against the count after this cycle's completion.
    assign base  = SUMW'(loads_pending) - SUMW'(load_done);
    assign cap0  = (base + SUMW'(if_id_mem_read0)) > SUMW'(MAX_LOADS);
    assign cap01 = (base + SUMW'(if_id_mem_read0) + SUMW'(if_id_mem_read1)) > SUMW'(MAX_LOADS);
    assign cap1  = (base + SUMW'(if_id_mem_read1)) > SUMW'(MAX_LOADS);

    always_comb begin
        stall      = 1'b0;
        issue0     = 1'b0;
        issue1     = 1'b0;
        next_state = state;
        if (!reset_n) begin
            next_state = ISSUE_RUN;
        end else if (flush) begin
            next_state = ISSUE_RUN;
        end else begin
            case (state)
                ISSUE_RUN: begin
                    if (if_id_valid) begin
                        if (blocked0 || cap0) begin
                            stall = 1'b1;
                        end else if (intra || blocked1 || cap01) begin
                            issue0     = 1'b1;
                            stall      = 1'b1;
                            next_state = ISSUE_SPLIT;
                        end else begin
                            issue0 = 1'b1;
                            issue1 = 1'b1;
                        end
                    end
                end
                ISSUE_SPLIT: begin
                    if (blocked1 || cap1) begin
                        stall = 1'b1;
                    end else begin
                        issue1     = 1'b1;
                        next_state = ISSUE_RUN;
                    end
                end
                default: next_state = ISSUE_RUN;
            endcase
        end
    end

    assign pending_next = SUMW'(loads_pending)
                        + SUMW'(issue0 && if_id_mem_read0)
                        + SUMW'(issue1 && if_id_mem_read1)
                        - SUMW'(load_done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ISSUE_RUN;
            first         <= 1'b0;
            loads_pending <= '0;
        end else begin
            state         <= next_state;
            first         <= (state == ISSUE_SPLIT) && issue1;
            loads_pending <= pending_next[CNTW-1:0];
        end
    end

    a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(load_done && (loads_pending == '0)));

endmodule
